// File: rtl/mem_sys_pkg.sv
// Shared memory-system definitions: responder FSM encoding and default geometry,
// reused by the data cache's refill logic.
package mem_sys_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int OFFS_W          = $clog2(DEF_BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        BURST = 2'd2,
        WWAIT = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with zero flag; times both read and write access latency.
module mem_latency_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_ms,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking (<=) so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_ms) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Main-memory responder: block-burst refills and single-word write-through stores.
// Optional macro RESP_BACKPRESSURE_EN adds resp_ready flow control on burst beats.
module data_mem_responder
    import mem_sys_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int BLOCK_WORDS   = DEF_BLOCK_WORDS,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           reset_ms,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [31:0]                    req_wdata,
`ifdef RESP_BACKPRESSURE_EN
    input  logic                           resp_ready,
`endif
    output logic                           resp_valid,
    output logic [31:0]                    resp_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] resp_word_idx,
    output logic                           resp_last,
    output logic                           wr_done
);

    localparam int OW      = $clog2(BLOCK_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    logic [31:0] mem [2**ADDR_W];

    mem_state_t        state, next_state;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              accept;
    logic              beat_take;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_value;
    logic              cnt_zero;
    logic [OW-1:0]     next_idx;
    logic [ADDR_W-1:0] beat_addr;

    assign req_ready = (state == IDLE) && !reset_ms;
    assign accept    = req_valid && req_ready;
    assign next_idx  = resp_word_idx + 1'b1;
    assign beat_addr = {lat_addr[ADDR_W-1:OW], next_idx};

`ifdef RESP_BACKPRESSURE_EN
    assign beat_take = resp_valid && resp_ready;
`else
    assign beat_take = resp_valid;
`endif

    mem_latency_counter #(.W(CNT_W)) u_lat_cnt (
        .clk        (clk),
        .reset_ms   (reset_ms),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        ((state == RWAIT) || (state == WWAIT)),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset_ms) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (req_we) begin
                        next_state     = WWAIT;
                        cnt_load_value = CNT_W'(WRITE_LATENCY - 1);
                    end else begin
                        next_state     = RWAIT;
                        cnt_load_value = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            RWAIT:   if (cnt_zero) next_state = BURST;
            BURST:   if (beat_take && resp_last) next_state = IDLE;
            WWAIT:   if (cnt_zero) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Beats are registered: the beat presented in cycle k was fetched at the edge before it.
    always_ff @(posedge clk) begin
        if (reset_ms) begin
            lat_addr      <= '0;
            lat_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_word_idx <= '0;
            resp_last     <= 1'b0;
            wr_done       <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (accept) begin
                lat_addr  <= req_we ? req_addr : {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                lat_wdata <= req_wdata;
            end
            case (state)
                RWAIT: begin
                    if (cnt_zero) begin
                        resp_valid    <= 1'b1;
                        resp_data     <= mem[lat_addr];
                        resp_word_idx <= '0;
                        resp_last     <= 1'b0;
                    end
                end
                BURST: begin
                    if (beat_take) begin
                        if (resp_last) begin
                            resp_valid    <= 1'b0;
                            resp_last     <= 1'b0;
                            resp_word_idx <= '0;
                        end else begin
                            resp_data     <= mem[beat_addr];
                            resp_word_idx <= next_idx;
                            resp_last     <= (next_idx == OW'(BLOCK_WORDS - 1));
                        end
                    end
                end
                WWAIT:   if (cnt_zero) wr_done <= 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: mem is deliberately not reset; reset_ms only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (!reset_ms && state == WWAIT && cnt_zero) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_ms = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_word_idx;
    logic        resp_last;
    logic        wr_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [1024];

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk           (clk),
        .reset_ms      (reset_ms),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
`ifdef RESP_BACKPRESSURE_EN
        .resp_ready    (resp_ready),
`endif
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_word_idx (resp_word_idx),
        .resp_last     (resp_last),
        .wr_done       (wr_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (wr_done) break;
            step();
        end
        check($sformatf("wr_%0h_done", a), wr_done, 1'b1);
        model[a] = d;
    endtask

    task automatic do_read(input logic [9:0] a, input string tag);
        logic [9:0] base;
        base = {a[9:2], 2'b00};
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0; req_addr = '1;
        for (int l = 0; l < 3; l++) begin
            check($sformatf("%s_lat%0d_valid", tag, l), resp_valid, 1'b0);
            check($sformatf("%s_lat%0d_ready", tag, l), req_ready, 1'b0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_b%0d_valid", tag, k), resp_valid, 1'b1);
            check($sformatf("%s_b%0d_idx", tag, k), resp_word_idx, k);
            check($sformatf("%s_b%0d_data", tag, k), resp_data, model[base + 10'(k)]);
            check($sformatf("%s_b%0d_last", tag, k), resp_last, k == 3);
            check($sformatf("%s_b%0d_ready", tag, k), req_ready, 1'b0);
            step();
        end
        check($sformatf("%s_end_valid", tag), resp_valid, 1'b0);
        check($sformatf("%s_end_ready", tag), req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         last_c;
        int         ready_c;
        logic [31:0] obs_data [16];
        logic [1:0]  obs_idx [16];

        // Reset state
        step();
        step();
        check("rst_ready", req_ready, 1'b0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_data", resp_data, 32'h0);
        check("rst_idx", resp_word_idx, 2'd0);
        check("rst_last", resp_last, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        reset_ms = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);

        // Write with exact latency: wr_done two cycles after acceptance
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h008; req_wdata = 32'hA;
        step();
        req_valid = 1'b0;
        check("w8_c0_ready", req_ready, 1'b0);
        check("w8_c0_done", wr_done, 1'b0);
        step();
        check("w8_c1_done", wr_done, 1'b0);
        step();
        check("w8_c2_done", wr_done, 1'b1);
        check("w8_mem", dut.mem[8], 32'hA);
        model[8] = 32'hA;
        step();
        check("w8_c3_done", wr_done, 1'b0);
        check("w8_c3_ready", req_ready, 1'b1);

        // Unaligned read of block 8
        do_write(10'h009, 32'h9999);
        do_write(10'h00A, 32'h1010_A0A0);
        do_write(10'h00B, 32'hB0B0_1111);
        do_read(10'h009, "rd9");

        // Read latency on block 0x50
        do_write(10'h050, 32'hC);
        do_write(10'h051, 32'h5151);
        do_write(10'h052, 32'hDEAD_BEEF);
        do_write(10'h053, 32'h0000_5353);
        do_read(10'h050, "lat");

        // Busy: second request held during a burst with changed address
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h052;
        step();
        req_addr = 10'h00A;
        n = 0; last_c = -1; ready_c = -1;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid && n < 16) begin
                obs_data[n] = resp_data;
                obs_idx[n]  = resp_word_idx;
                n++;
                if (resp_last && last_c < 0) last_c = c;
            end
            if (req_valid && req_ready && ready_c < 0) ready_c = c;
            step();
            if (ready_c >= 0) req_valid = 1'b0;
        end
        check("busy_first_ready", ready_c, last_c + 1);
        check("busy_beats", n, 8);
        for (int k = 0; k < 8 && k < n; k++) begin
            check($sformatf("busy_b%0d_idx", k), obs_idx[k], k % 4);
            check($sformatf("busy_b%0d_data", k), obs_data[k],
                  (k < 4) ? model[10'h050 + 10'(k)] : model[10'h008 + 10'(k - 4)]);
        end

        // Reset mid-burst at beat 1
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h008;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        check("rmb_beat1_idx", resp_word_idx, 2'd1);
        reset_ms = 1'b1;
        step();
        check("rmb_valid", resp_valid, 1'b0);
        check("rmb_ready_in_rst", req_ready, 1'b0);
        step();
        check("rmb_valid2", resp_valid, 1'b0);
        reset_ms = 1'b0;
        #1;
        check("rmb_ready_after", req_ready, 1'b1);
        do_read(10'h00B, "rmb_rd");

        // Reset during a pending write: write dropped
        do_write(10'h00F, 32'h55);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h00F; req_wdata = 32'hC0;
        step();
        req_valid = 1'b0;
        reset_ms = 1'b1;
        step();
        check("rw_done_r0", wr_done, 1'b0);
        step();
        check("rw_done_r1", wr_done, 1'b0);
        reset_ms = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rw_done_p%0d", c), wr_done, 1'b0);
        end
        check("rw_mem", dut.mem[15], 32'h55);

`ifdef RESP_BACKPRESSURE_EN
        // Backpressure: hold beat 2
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h008;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        check("bp_b2_idx", resp_word_idx, 2'd2);
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_hold%0d_valid", c), resp_valid, 1'b1);
            check($sformatf("bp_hold%0d_idx", c), resp_word_idx, 2'd2);
            check($sformatf("bp_hold%0d_data", c), resp_data, model[10]);
        end
        resp_ready = 1'b1;
        step();
        check("bp_b3_idx", resp_word_idx, 2'd3);
        check("bp_b3_data", resp_data, model[11]);
        check("bp_b3_last", resp_last, 1'b1);
        step();
        check("bp_end_valid", resp_valid, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
